// File: rtl/xpb_table_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : xpb_table_gen_if
// Description : Table-RAM write port (valid/ready) of the xpb table generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface xpb_table_gen_if #(
    parameter int WIDTH    = 1024,
    parameter int IDX_BITS = 5
);
    logic                wr_valid;
    logic                wr_ready;
    logic [IDX_BITS-1:0] wr_addr;
    logic [WIDTH-1:0]    wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/xpb_table_gen.sv
`default_nettype none
// ============================================================================
// Module      : xpb_table_gen
// Description : Streams entry[i] = (i*B) mod M, i = 0..2^IDX_BITS-1, built by
//               repeated modular addition, onto a valid/ready table write port.
// Revision    : 1.0 - initial release
// ============================================================================
module xpb_table_gen #(
    parameter int WIDTH    = 1024,
    parameter int IDX_BITS = 5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic [WIDTH-1:0] modulus,
    input  wire logic [WIDTH-1:0] base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    xpb_table_gen_if.master       wr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EMIT   = 3'd1,
        S_ADD    = 3'd2,
        S_REDUCE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [IDX_BITS-1:0] C_LAST_IDX = {IDX_BITS{1'b1}};

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_mod;
    logic [WIDTH-1:0]    r_base;
    logic [WIDTH-1:0]    r_acc;
    logic [WIDTH:0]      r_sum;
    logic [IDX_BITS-1:0] r_idx;
    logic                r_err;
    logic [WIDTH-1:0]    w_diff;
    logic                w_start_ok;
    logic                w_accept;
    logic                w_reject;
    logic                w_hs;
    logic                w_last;

    assign w_start_ok = (base < modulus);
    assign w_accept   = (r_state == S_IDLE) && start && w_start_ok;
    assign w_reject   = (r_state == S_IDLE) && start && !w_start_ok;
    assign w_hs       = (r_state == S_EMIT) && wr.wr_ready;
    assign w_last     = (r_idx == C_LAST_IDX);
    // Since acc < M and B < M, sum - M < 2^WIDTH, so the low WIDTH bits suffice.
    assign w_diff     = r_sum[WIDTH-1:0] - r_mod;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_EMIT;
            S_EMIT:   if (w_hs)     w_next = w_last ? S_DONE : S_ADD;
            S_ADD:    w_next = S_REDUCE;
            S_REDUCE: w_next = S_EMIT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mod  <= '0;
            r_base <= '0;
            r_acc  <= '0;
            r_sum  <= '0;
            r_idx  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_mod  <= modulus;
                r_base <= base;
                r_acc  <= '0;
                r_idx  <= '0;
            end
            if (w_hs && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == S_ADD) begin
                r_sum <= {1'b0, r_acc} + {1'b0, r_base};
            end
            if (r_state == S_REDUCE) begin
                r_acc <= (r_sum >= {1'b0, r_mod}) ? w_diff : r_sum[WIDTH-1:0];
            end
        end
    end

    // acc only moves in REDUCE, so wr_data naturally holds between entries.
    assign wr.wr_valid = (r_state == S_EMIT);
    assign wr.wr_addr  = r_idx;
    assign wr.wr_data  = r_acc;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xpb_table_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_xpb_table_gen
// Description : Directed bench for xpb_table_gen, small (8b/8 entry) and
//               default (1024b/32 entry) configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xpb_table_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       s_rst, s_start, s_busy, s_done, s_err;
    logic [7:0] s_mod, s_base;

    logic          b_rst, b_start, b_busy, b_done, b_err;
    logic [1023:0] b_mod, b_base;
    logic [1023:0] big_m, big_b;

    xpb_table_gen_if #(.WIDTH(8), .IDX_BITS(3)) sif ();
    xpb_table_gen_if #(.WIDTH(1024), .IDX_BITS(5)) bif ();

    xpb_table_gen #(.WIDTH(8), .IDX_BITS(3)) dut_small (
        .clk(clk), .reset(s_rst), .start(s_start), .modulus(s_mod), .base(s_base),
        .busy(s_busy), .done(s_done), .err(s_err), .wr(sif)
    );

    xpb_table_gen #(.WIDTH(1024), .IDX_BITS(5)) dut_big (
        .clk(clk), .reset(b_rst), .start(b_start), .modulus(b_mod), .base(b_base),
        .busy(b_busy), .done(b_done), .err(b_err), .wr(bif)
    );

    task automatic chk(input string tag, input logic [1024:0] obs, input logic [1024:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h..%h expected=%h..%h", tag,
                   obs[1024:896], obs[127:0], exp[1024:896], exp[127:0]);
        end
    endtask

    // M = 2^1023+1 and B = M-1, so (i*B) mod M = M - i for i >= 1.
    function automatic logic [1023:0] big_exp(input int i);
        return (i == 0) ? 1024'd0 : big_m - 1024'(i);
    endfunction

    task automatic run_small(input int m, input int b, input bit rnd, input bit timing,
                             input bit poke);
        int n = 0, c = 0, dones = 0;
        bit stall = 0;
        logic [2:0] pa = '0;
        logic [7:0] pd = '0;
        @(negedge clk);
        s_mod = 8'(m); s_base = 8'(b); s_start = 1'b1; sif.wr_ready = 1'b1;
        @(negedge clk);
        s_start = 1'b0; c = 1;
        chk("small_busy_after_start", s_busy, 1);
        while (dones == 0 && c < 300) begin
            if (poke) begin
                s_start = (c == 5);
                if (c == 5) begin s_mod = 8'd3; s_base = 8'd2; end
            end
            sif.wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sif.wr_valid) begin
                if (stall) begin
                    chk("small_stall_addr", sif.wr_addr, pa);
                    chk("small_stall_data", sif.wr_data, pd);
                end
                chk("small_addr", sif.wr_addr, n);
                chk("small_data", sif.wr_data, (n * b) % m);
                if (timing) chk("small_emit_cycle", c, 1 + 3 * n);
                if (sif.wr_ready) begin
                    n++; stall = 0;
                end else begin
                    stall = 1; pa = sif.wr_addr; pd = sif.wr_data;
                end
            end
            if (s_done) begin
                dones++;
                chk("small_writes_at_done", n, 8);
                chk("small_busy_in_done", s_busy, 1);
                if (timing) chk("small_done_cycle", c, 23);
            end
            @(negedge clk);
            c++;
        end
        s_start = 1'b0;
        chk("small_done_seen", dones, 1);
        chk("small_done_one_cycle", s_done, 0);
        chk("small_busy_after_done", s_busy, 0);
        chk("small_valid_after_done", sif.wr_valid, 0);
    endtask

    task automatic run_big(input int rst_at, input bit rnd);
        int n = 0, c = 0, dones = 0, bad = 0;
        bit stall = 0;
        logic [4:0]    pa = '0;
        logic [1023:0] pd = '0;
        @(negedge clk);
        b_mod = big_m; b_base = big_b; b_start = 1'b1; bif.wr_ready = 1'b1;
        @(negedge clk);
        b_start = 1'b0; b_mod = '0; b_base = '0; c = 1;
        while (dones == 0 && c < 600) begin
            bif.wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bif.wr_valid) begin
                if (stall) begin
                    chk("big_stall_addr", bif.wr_addr, pa);
                    chk("big_stall_data", bif.wr_data, pd);
                end
                chk("big_addr", bif.wr_addr, n);
                chk("big_data", bif.wr_data, big_exp(n));
                if (!rnd) chk("big_emit_cycle", c, 1 + 3 * n);
                if (rst_at >= 0 && n == rst_at) begin
                    b_rst = 1'b1;
                    @(negedge clk);
                    b_rst = 1'b0;
                    chk("big_rst_valid", bif.wr_valid, 0);
                    chk("big_rst_addr", bif.wr_addr, 0);
                    chk("big_rst_busy", b_busy, 0);
                    chk("big_rst_done", b_done, 0);
                    repeat (40) begin
                        @(negedge clk);
                        if (bif.wr_valid || b_done || b_busy) bad++;
                    end
                    chk("big_quiet_after_reset", bad, 0);
                    return;
                end
                if (bif.wr_ready) begin
                    n++; stall = 0;
                end else begin
                    stall = 1; pa = bif.wr_addr; pd = bif.wr_data;
                end
            end
            if (b_done) begin
                dones++;
                chk("big_writes_at_done", n, 32);
                if (!rnd) chk("big_done_cycle", c, 95);
            end
            @(negedge clk);
            c++;
        end
        chk("big_done_seen", dones, 1);
        chk("big_done_one_cycle", b_done, 0);
        chk("big_busy_after_done", b_busy, 0);
    endtask

    initial begin
        big_m = {1'b1, {1022{1'b0}}, 1'b1};
        big_b = {1'b1, {1023{1'b0}}};
        s_rst = 1'b1; s_start = 1'b0; s_mod = '0; s_base = '0; sif.wr_ready = 1'b0;
        b_rst = 1'b1; b_start = 1'b0; b_mod = '0; b_base = '0; bif.wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_small_valid", sif.wr_valid, 0);
        chk("rst_small_addr", sif.wr_addr, 0);
        chk("rst_small_data", sif.wr_data, 0);
        chk("rst_small_busy", s_busy, 0);
        chk("rst_small_done", s_done, 0);
        chk("rst_small_err", s_err, 0);
        chk("rst_big_valid", bif.wr_valid, 0);
        chk("rst_big_data", bif.wr_data, 0);
        chk("rst_big_busy", b_busy, 0);
        s_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);

        run_small(7, 1, 0, 1, 0);
        run_small(13, 12, 0, 1, 0);

        // base == modulus is rejected
        @(negedge clk);
        s_mod = 8'd5; s_base = 8'd5; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("err_pulse", s_err, 1);
        chk("err_busy", s_busy, 0);
        chk("err_valid", sif.wr_valid, 0);
        @(negedge clk);
        chk("err_one_cycle", s_err, 0);
        chk("err_busy_later", s_busy, 0);
        chk("err_valid_later", sif.wr_valid, 0);

        run_small(13, 12, 0, 1, 1);
        run_small(11, 7, 1, 0, 0);

        run_big(-1, 0);
        run_big(10, 0);
        run_big(-1, 0);
        run_big(-1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
